// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage.
package exec_pkg;

  localparam int unsigned SHAMT_W = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/exec_mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, W steps total.
module exec_mul_seq #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod,
  output logic           last
);

  localparam int unsigned CW = $clog2(W) + 1;

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  idx;
  logic           active;

  // Bit 0 of b is consumed on the go edge, so last rises after W-1 more steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      idx    <= '0;
      active <= 1'b0;
      last   <= 1'b0;
    end else begin
      last <= 1'b0;
      if (go) begin
        prod   <= b[0] ? {{W{1'b0}}, a} : '0;
        mcand  <= {{(W-1){1'b0}}, a, 1'b0};
        mplier <= b >> 1;
        idx    <= CW'(1);
        active <= (W > 1);
        last   <= (W == 1);
      end else if (active) begin
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        idx    <= idx + CW'(1);
        if (idx == CW'(W - 1)) begin
          active <= 1'b0;
          last   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: one ALU op per accepted request, register-file write-back and flags.
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned D = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] zero_val,
  input  logic [W-1:0] other_val,
  input  logic [D-1:0] dest_addr,
  input  logic         dest_zero,
  output logic         busy,
  output logic         done,
  output logic         wb_en,
  output logic         wb_zero_store,
  output logic [D-1:0] wb_addr,
  output logic [W-1:0] wb_data,
  output logic         carry_flag,
  output logic         zero_flag
);

  state_t             state;
  op_t                op_i, op_q;
  logic [W-1:0]       sh_q, sh_next, alu_res;
  logic               sh_out, alu_c;
  logic [SHAMT_W-1:0] cnt, amt;
  logic [W:0]         wide;
  logic [2*W-1:0]     prod;
  logic               mul_go, mul_last;

  assign op_i   = op_t'(op);
  assign amt    = other_val[SHAMT_W-1:0];
  assign mul_go = (state == IDLE) && start && (op_i == OP_MUL);

  exec_mul_seq #(.W(W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (mul_go),
    .a     (zero_val),
    .b     (other_val),
    .prod  (prod),
    .last  (mul_last)
  );

  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_i)
      OP_ADD: begin
        wide    = {1'b0, zero_val} + {1'b0, other_val};
        alu_res = wide[W-1:0];
        alu_c   = wide[W];
      end
      OP_SUB, OP_CMP: begin
        wide    = {1'b0, zero_val} - {1'b0, other_val};
        alu_res = wide[W-1:0];
        alu_c   = wide[W];
      end
      OP_AND:  alu_res = zero_val & other_val;
      OP_XOR:  alu_res = zero_val ^ other_val;
      default: alu_res = zero_val;  // zero-amount shift passes A through
    endcase
  end

  always_comb begin
    sh_next = (op_q == OP_SHL) ? (sh_q << 1) : (sh_q >> 1);
    sh_out  = (op_q == OP_SHL) ? sh_q[W-1] : sh_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= OP_ADD;
      sh_q          <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      wb_en         <= 1'b0;
      wb_zero_store <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      carry_flag    <= 1'b0;
      zero_flag     <= 1'b0;
    end else begin
      done  <= 1'b0;
      wb_en <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q          <= op_i;
          wb_addr       <= dest_addr;
          wb_zero_store <= dest_zero;
          busy          <= 1'b1;
          if (op_i == OP_MUL) begin
            state <= MUL;
          end else if ((op_i == OP_SHL || op_i == OP_SHR) && amt != '0) begin
            state <= SHIFT;
            sh_q  <= zero_val;
            cnt   <= amt;
          end else begin
            state      <= DONE;
            done       <= 1'b1;
            wb_en      <= (op_i != OP_CMP);
            wb_data    <= alu_res;
            carry_flag <= alu_c;
            zero_flag  <= (alu_res == '0);
          end
        end
        SHIFT: begin
          sh_q <= sh_next;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state      <= DONE;
            done       <= 1'b1;
            wb_en      <= 1'b1;
            wb_data    <= sh_next;
            carry_flag <= sh_out;
            zero_flag  <= (sh_next == '0);
          end
        end
        MUL: if (mul_last) begin
          state      <= DONE;
          done       <= 1'b1;
          wb_en      <= 1'b1;
          wb_data    <= prod[W-1:0];
          carry_flag <= |prod[2*W-1:W];
          zero_flag  <= (prod[W-1:0] == '0);
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed-vector bench for exec_unit with hand-computed expectations.
module tb_exec_unit;
  import exec_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] zero_val = '0, other_val = '0;
  logic [2:0] dest_addr = '0;
  logic       dest_zero = 1'b0;
  logic       busy, done, wb_en, wb_zero_store, carry_flag, zero_flag;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;

  int errs = 0;
  int checks = 0;

  exec_unit #(.W(8), .D(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .zero_val(zero_val), .other_val(other_val),
    .dest_addr(dest_addr), .dest_zero(dest_zero),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_zero_store(wb_zero_store),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .carry_flag(carry_flag), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic [2:0] addr;
    logic       dz;
    int         lat;
    logic       wben;
    logic [7:0] data;
    logic       c, z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one request, scramble inputs after accept, and return the latency to done.
  task automatic launch(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] addr, input logic dz, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; zero_val = a; other_val = b; dest_addr = addr; dest_zero = dz;
    @(negedge clk);
    start = 1'b0; op = o ^ 3'b101; zero_val = ~a; other_val = ~b;
    dest_addr = ~addr; dest_zero = ~dz;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    launch(v.op, v.a, v.b, v.addr, v.dz, lat);
    if (!done) begin
      chk({tag, ".timeout"}, 32'(done), 32'd1);
    end else begin
      chk({tag, ".lat"}, 32'(lat), 32'(v.lat));
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".wb_en"}, 32'(wb_en), 32'(v.wben));
      chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(v.addr));
      chk({tag, ".wb_zs"}, 32'(wb_zero_store), 32'(v.dz));
      chk({tag, ".wb_data"}, 32'(wb_data), 32'(v.data));
      chk({tag, ".carry"}, 32'(carry_flag), 32'(v.c));
      chk({tag, ".zero"}, 32'(zero_flag), 32'(v.z));
    end
    @(negedge clk);
    chk({tag, ".done_drop"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".carry_hold"}, 32'(carry_flag), 32'(v.c));
    chk({tag, ".zero_hold"}, 32'(zero_flag), 32'(v.z));
  endtask

  vec_t vecs[16];

  initial begin
    int lat, ndone, nwb;

    vecs[0]  = '{OP_ADD, 8'hF0, 8'h20, 3'd3, 1'b0, 1, 1'b1, 8'h10, 1'b1, 1'b0};
    vecs[1]  = '{OP_CMP, 8'h05, 8'h05, 3'd1, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{OP_SUB, 8'h03, 8'h05, 3'd2, 1'b0, 1, 1'b1, 8'hFE, 1'b1, 1'b0};
    vecs[3]  = '{OP_SHL, 8'h81, 8'h03, 3'd4, 1'b0, 4, 1'b1, 8'h08, 1'b0, 1'b0};
    vecs[4]  = '{OP_SHR, 8'h01, 8'h00, 3'd5, 1'b0, 1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{OP_MUL, 8'h10, 8'h11, 3'd6, 1'b1, 9, 1'b1, 8'h10, 1'b1, 1'b0};
    vecs[6]  = '{OP_AND, 8'hF0, 8'h0F, 3'd7, 1'b0, 1, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{OP_XOR, 8'hA5, 8'hFF, 3'd0, 1'b1, 1, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[8]  = '{OP_SHR, 8'h81, 8'h0A, 3'd1, 1'b0, 3, 1'b1, 8'h20, 1'b0, 1'b0};
    vecs[9]  = '{OP_SHR, 8'h03, 8'h02, 3'd2, 1'b0, 3, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[10] = '{OP_SHL, 8'h80, 8'h01, 3'd3, 1'b1, 2, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[11] = '{OP_MUL, 8'hFF, 8'hFF, 3'd4, 1'b0, 9, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[12] = '{OP_MUL, 8'h03, 8'h05, 3'd5, 1'b0, 9, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[13] = '{OP_ADD, 8'hFF, 8'h01, 3'd6, 1'b0, 1, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[14] = '{OP_SHL, 8'h01, 8'h07, 3'd7, 1'b0, 8, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[15] = '{OP_CMP, 8'h03, 8'h09, 3'd1, 1'b1, 1, 1'b0, 8'hFA, 1'b1, 1'b0};

    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.wb_en", 32'(wb_en), 32'd0);
    chk("rst.wb_addr", 32'(wb_addr), 32'd0);
    chk("rst.wb_data", 32'(wb_data), 32'd0);
    chk("rst.flags", 32'({carry_flag, zero_flag, wb_zero_store}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // A second start mid-MUL must be dropped: exactly one done, MUL result kept.
    @(negedge clk);
    start = 1'b1; op = OP_MUL; zero_val = 8'h10; other_val = 8'h11;
    dest_addr = 3'd2; dest_zero = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; nwb = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 3) begin
        start = 1'b1; op = OP_ADD; zero_val = 8'h01; other_val = 8'h01;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        chk("dbl.wb_data", 32'(wb_data), 32'h10);
        chk("dbl.wb_zs", 32'(wb_zero_store), 32'd1);
        chk("dbl.lat", 32'(c + 1), 32'd9);
      end
      @(negedge clk);
    end
    chk("dbl.ndone", 32'(ndone), 32'd1);

    // Reset 4 cycles into a MUL: outputs clear at once and nothing is written.
    launch(OP_ADD, 8'h00, 8'h01, 3'd0, 1'b0, lat);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_MUL; zero_val = 8'h07; other_val = 8'h09;
    dest_addr = 3'd5; dest_zero = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.wb_addr", 32'(wb_addr), 32'd0);
    chk("arst.wb_zs", 32'(wb_zero_store), 32'd0);
    chk("arst.wb_data", 32'(wb_data), 32'd0);
    chk("arst.carry", 32'(carry_flag), 32'd0);
    chk("arst.done_wb", 32'({done, wb_en}), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (wb_en || done) nwb++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (wb_en || done || busy) nwb++;
    end
    chk("arst.no_wb", 32'(nwb), 32'd0);
    run_vec('{OP_ADD, 8'h01, 8'h01, 3'd3, 1'b0, 1, 1'b1, 8'h02, 1'b0, 1'b0}, "post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage directly downstream of the register file, consuming its two read values: the zero register value (zero_val) and the selected other register value (other_val).
- Performs one ALU operation per accepted request. Operations take one cycle or several cycles, depending on the operation.
- Drives the register file's write-back controls (write enable, zero_store select, write address, write data).
- Holds condition flags for the sequencer.

Parameters:
W, 8, datapath width in bits.
D, 3, register address width in bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request strobe. Accepted only when busy=0.
op  input  3  operation code; encodings are in Behaviour.
zero_val  input  W  operand A, taken from the zero register.
other_val  input  W  operand B, taken from the selected register.
dest_addr  input  D  write-back register address.
dest_zero  input  1  when 1, the result is written to register 0 regardless of dest_addr.
busy  output  1  high from the cycle after accept through the done cycle.
done  output  1  one-cycle pulse when the result is valid.
wb_en  output  1  register write enable; pulses together with done.
wb_zero_store  output  1  registered copy of dest_zero.
wb_addr  output  D  registered copy of dest_addr.
wb_data  output  W  result.
carry_flag  output  1  carry, borrow or overflow indication.
zero_flag  output  1  set when the result is 0.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - busy, done, wb_en, wb_zero_store, carry_flag and zero_flag reset to 0.
  - wb_addr and wb_data reset to 0.
  - An operation in progress at reset is aborted with no write-back.
- Accept:
  - A request is accepted when start=1 and the state is IDLE.
  - On accept, op, both operands, dest_addr and dest_zero are latched. Later changes on these inputs are ignored.
  - start while busy=1 is dropped silently. It is not queued.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 XOR.
  - 100 SHL: shift A left by B[2:0].
  - 101 SHR: logical shift A right by B[2:0].
  - 110 MUL: low W bits of A*B.
  - 111 CMP: flags only, no write-back.
- State machine states: IDLE, SHIFT, MUL, DONE.
  - IDLE->DONE when the accepted op is 000-011 or 111, or a shift with amount 0. The result is computed at accept.
  - IDLE->SHIFT when the op is a shift with amount n>0. Shifts one bit per cycle for n cycles, then goes to DONE.
  - IDLE->MUL for op 110. Shift-add multiply over W cycles, one multiplier bit per cycle, then goes to DONE.
  - DONE->IDLE unconditionally. A new start can be accepted in the cycle after DONE.
- Latency from the accept edge to the done pulse:
  - Single-cycle ops: 1 cycle.
  - Shift by n: n+1 cycles.
  - MUL: W+1 cycles (9 when W=8).
- In the DONE state:
  - done=1.
  - wb_en=1 unless op=111.
  - wb_data holds the result (for CMP it holds A-B but is not written).
  - Flags update in the same cycle and hold until the next DONE.
- busy=1 in SHIFT, MUL and DONE, and also in the cycle after accept (always one of those states).
- carry_flag by op:
  - ADD: carry-out of bit W-1.
  - SUB and CMP: borrow, i.e. 1 when A<B unsigned.
  - SHL and SHR: the last bit shifted out; 0 when the amount is 0.
  - MUL: 1 when the upper W bits of the 2W-bit product are nonzero.
  - AND and XOR: 0.
- zero_flag = (wb_data == 0) for all ops, including CMP.
- All arithmetic is unsigned and wraps modulo 2^W.
- Only B[2:0] is used as the shift amount, so shifts range 0..7. Other bits of B are ignored.

Decomposition:
- Shared package exec_pkg holds:
  - typedef enum logic [2:0] op_t with OP_ADD … OP_CMP;
  - typedef enum state_t {IDLE, SHIFT, MUL, DONE};
  - constant SHAMT_W = 3.
- One sub-module, exec_mul_seq: sequential shift-add multiplier.
  - Inputs: clk, rst_n, go, a, b.
  - Outputs: prod (2W bits) and last.
  - The exec_unit FSM owns the cycle count and write-back.

Test Plan:
- ADD with A=0xF0, B=0x20, dest_addr=3, dest_zero=0 -> done 1 cycle after accept; wb_en=1, wb_addr=3, wb_data=0x10, carry=1, zero=0.
- CMP with A=0x05, B=0x05, then SUB with A=0x03, B=0x05 -> CMP: wb_en=0, zero=1, carry=0. SUB: wb_data=0xFE, carry=1, wb_en=1.
- SHL with A=0x81, B=0x03 -> busy for 4 cycles, done on the 4th; wb_data=0x08, carry=0. SHR with A=0x01, B=0x00 -> 1-cycle latency, wb_data=0x01, carry=0.
- MUL with A=0x10, B=0x11, dest_zero=1 -> done 9 cycles after accept; wb_data=0x10, carry=1, wb_zero_store=1. A second start mid-operation is ignored: exactly one done.
- Reset mid-MUL: drop rst_n 4 cycles after accept -> all outputs 0 immediately (async), no wb_en pulse. After release, an ADD with A=1, B=1 completes normally with wb_data=0x02.
